// File: rtl/bpf_code_loader_if.sv
// rtl/bpf_code_loader_if.sv - configuration beat channel for the BPF code loader
//
// Purpose : carries 32-bit configuration beats (opcode + payload) with a
//           valid/ready handshake from the host side into the loader.
// Signals : cfg_op     [1:0]  beat opcode: 00 DATA, 01 BEGIN, 10 COMMIT, 11 ABORT
//           cfg_wdata  [31:0] DATA payload
//           cfg_wvalid        beat valid (driven by master)
//           cfg_wready        beat ready (driven by slave)
interface bpf_code_loader_if;
  logic [1:0]  cfg_op;
  logic [31:0] cfg_wdata;
  logic        cfg_wvalid;
  logic        cfg_wready;

  modport master (
    output cfg_op,
    output cfg_wdata,
    output cfg_wvalid,
    input  cfg_wready
  );

  modport slave (
    input  cfg_op,
    input  cfg_wdata,
    input  cfg_wvalid,
    output cfg_wready
  );
endinterface

// File: rtl/bpf_code_loader.sv
// rtl/bpf_code_loader.sv - packs config beats into BPF instructions and owns filter start
//
// Purpose : sequences instruction-memory rewrites for the packet filter. Two
//           32-bit DATA beats (lo then hi) form one 64-bit instruction. Before
//           any rewrite the filters are stopped and must report idle.
// Ports   : clk, rst_n        clock, asynchronous active-low reset
//           cfg (slave)       configuration beat channel
//           filt_idle         all filter cores idle (only looked at in DRAIN)
//           inst_wr_addr/data/en  instruction memory write port (1-cycle strobe)
//           control_start     filters enabled (level)
//           loaded_len        instructions written since last BEGIN
//           busy              in DRAIN or LOADING
//           err_overflow/err_odd/err_seq  sticky error flags, cleared by BEGIN
module bpf_code_loader #(
  parameter int INST_MEM_DEPTH  = 512,
  parameter int CODE_ADDR_WIDTH = 9,
  parameter int CODE_DATA_WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  bpf_code_loader_if.slave           cfg,
  input  logic                       filt_idle,
  output logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr,
  output logic [CODE_DATA_WIDTH-1:0] inst_wr_data,
  output logic                       inst_wr_en,
  output logic                       control_start,
  output logic [CODE_ADDR_WIDTH:0]   loaded_len,
  output logic                       busy,
  output logic                       err_overflow,
  output logic                       err_odd,
  output logic                       err_seq
);

  localparam int LW = CODE_ADDR_WIDTH + 1;
  localparam logic [LW-1:0] FULL_LEN = LW'(INST_MEM_DEPTH);

  localparam logic [1:0] OP_DATA   = 2'b00;
  localparam logic [1:0] OP_BEGIN  = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_RUNNING = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_LOADING = 2'd3
  } state_t;

  state_t state, next_state;

  // Registered state beyond the FSM. The write pointer is the instruction
  // count itself: every write lands at slot loaded_len, and the extra MSB of
  // loaded_len lets it reach INST_MEM_DEPTH without wrapping.
  logic        cfg_wready_q;
  logic        half;
  logic [31:0] lo;

  logic                       cfg_wready_d, half_d, inst_wr_en_d, control_start_d;
  logic                       busy_d, err_overflow_d, err_odd_d, err_seq_d;
  logic [31:0]                lo_d;
  logic [LW-1:0]              loaded_len_d;
  logic [CODE_ADDR_WIDTH-1:0] inst_wr_addr_d;
  logic [CODE_DATA_WIDTH-1:0] inst_wr_data_d;

  logic accept;
  assign accept         = cfg.cfg_wvalid & cfg_wready_q;
  assign cfg.cfg_wready = cfg_wready_q;

  // State register together with every registered output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_STOPPED;
      cfg_wready_q  <= 1'b1;
      half          <= 1'b0;
      lo            <= '0;
      loaded_len    <= '0;
      inst_wr_en    <= 1'b0;
      inst_wr_addr  <= '0;
      inst_wr_data  <= '0;
      control_start <= 1'b0;
      busy          <= 1'b0;
      err_overflow  <= 1'b0;
      err_odd       <= 1'b0;
      err_seq       <= 1'b0;
    end else begin
      state         <= next_state;
      cfg_wready_q  <= cfg_wready_d;
      half          <= half_d;
      lo            <= lo_d;
      loaded_len    <= loaded_len_d;
      inst_wr_en    <= inst_wr_en_d;
      inst_wr_addr  <= inst_wr_addr_d;
      inst_wr_data  <= inst_wr_data_d;
      control_start <= control_start_d;
      busy          <= busy_d;
      err_overflow  <= err_overflow_d;
      err_odd       <= err_odd_d;
      err_seq       <= err_seq_d;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      ST_STOPPED: begin
        if (accept && cfg.cfg_op == OP_BEGIN) next_state = ST_DRAIN;
      end
      ST_RUNNING: begin
        if (accept && cfg.cfg_op == OP_BEGIN)      next_state = ST_DRAIN;
        else if (accept && cfg.cfg_op == OP_ABORT) next_state = ST_STOPPED;
      end
      ST_DRAIN: begin
        // control_start is already low on DRAIN entry; the check keeps the
        // guarantee local rather than relying on the entry path.
        if (filt_idle && !control_start) next_state = ST_LOADING;
      end
      ST_LOADING: begin
        if (accept) begin
          case (cfg.cfg_op)
            OP_BEGIN:  next_state = ST_DRAIN;
            OP_ABORT:  next_state = ST_STOPPED;
            OP_COMMIT: next_state = ST_RUNNING;
            default:   next_state = ST_LOADING;
          endcase
        end
      end
      default: next_state = ST_STOPPED;
    endcase
  end

  // Next values of the registered outputs and datapath.
  always_comb begin
    half_d          = half;
    lo_d            = lo;
    loaded_len_d    = loaded_len;
    inst_wr_en_d    = 1'b0;
    inst_wr_addr_d  = inst_wr_addr;
    inst_wr_data_d  = inst_wr_data;
    control_start_d = control_start;
    err_overflow_d  = err_overflow;
    err_odd_d       = err_odd;
    err_seq_d       = err_seq;

    if (accept) begin
      case (cfg.cfg_op)
        OP_BEGIN: begin
          control_start_d = 1'b0;
          loaded_len_d    = '0;
          half_d          = 1'b0;
          err_overflow_d  = 1'b0;
          err_odd_d       = 1'b0;
          err_seq_d       = 1'b0;
        end
        OP_ABORT: begin
          control_start_d = 1'b0;
          half_d          = 1'b0;
        end
        OP_DATA: begin
          if (state != ST_LOADING) begin
            err_seq_d = 1'b1;
          end else if (loaded_len == FULL_LEN) begin
            err_overflow_d = 1'b1;
          end else if (!half) begin
            lo_d   = cfg.cfg_wdata;
            half_d = 1'b1;
          end else begin
            inst_wr_en_d   = 1'b1;
            inst_wr_addr_d = loaded_len[CODE_ADDR_WIDTH-1:0];
            inst_wr_data_d = {cfg.cfg_wdata, lo};
            loaded_len_d   = loaded_len + LW'(1);
            half_d         = 1'b0;
          end
        end
        default: begin // OP_COMMIT
          if (state != ST_LOADING) begin
            err_seq_d = 1'b1;
          end else begin
            if (half) err_odd_d = 1'b1;
            half_d          = 1'b0;
            control_start_d = 1'b1;
          end
        end
      endcase
    end

    cfg_wready_d = (next_state != ST_DRAIN);
    busy_d       = (next_state == ST_DRAIN) || (next_state == ST_LOADING);
  end

endmodule

// File: tb/tb_bpf_code_loader.sv
// tb/tb_bpf_code_loader.sv - directed self-checking bench for bpf_code_loader
module tb_bpf_code_loader;

  localparam logic [1:0] OP_DATA   = 2'b00;
  localparam logic [1:0] OP_BEGIN  = 2'b01;
  localparam logic [1:0] OP_COMMIT = 2'b10;
  localparam logic [1:0] OP_ABORT  = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        filt_idle = 1'b1;
  logic [8:0]  inst_wr_addr;
  logic [63:0] inst_wr_data;
  logic        inst_wr_en;
  logic        control_start;
  logic [9:0]  loaded_len;
  logic        busy;
  logic        err_overflow;
  logic        err_odd;
  logic        err_seq;

  int n_cmp = 0;
  int n_bad = 0;

  logic [8:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];

  bpf_code_loader_if cfg_if ();

  bpf_code_loader #(
    .INST_MEM_DEPTH (512),
    .CODE_ADDR_WIDTH(9),
    .CODE_DATA_WIDTH(64)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg          (cfg_if),
    .filt_idle    (filt_idle),
    .inst_wr_addr (inst_wr_addr),
    .inst_wr_data (inst_wr_data),
    .inst_wr_en   (inst_wr_en),
    .control_start(control_start),
    .loaded_len   (loaded_len),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_odd      (err_odd),
    .err_seq      (err_seq)
  );

  always #5 clk = ~clk;

  // Log every write strobe, sampled away from the active edge.
  always @(negedge clk) begin
    if (inst_wr_en === 1'b1) begin
      wr_addr_q.push_back(inst_wr_addr);
      wr_data_q.push_back(inst_wr_data);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Present one beat; called #1 after a rising edge, returns #1 after the
  // edge that accepts it.
  task automatic beat(input logic [1:0] op, input logic [31:0] data);
    cfg_if.cfg_op     = op;
    cfg_if.cfg_wdata  = data;
    cfg_if.cfg_wvalid = 1'b1;
    @(posedge clk);
    #1;
    cfg_if.cfg_wvalid = 1'b0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cfg_if.cfg_wready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_ready", {63'd0, cfg_if.cfg_wready}, 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    cfg_if.cfg_op     = OP_DATA;
    cfg_if.cfg_wdata  = '0;
    cfg_if.cfg_wvalid = 1'b0;

    // Reset state
    idle_cycles(2);
    chk("rst_wready", {63'd0, cfg_if.cfg_wready}, 64'd1);
    chk("rst_start", {63'd0, control_start}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_len", {54'd0, loaded_len}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Test 1: single instruction load and commit
    beat(OP_BEGIN, 32'h0);
    chk("t1_drain_wready", {63'd0, cfg_if.cfg_wready}, 64'd0);
    chk("t1_drain_busy", {63'd0, busy}, 64'd1);
    wait_ready();
    wr_addr_q.delete();
    wr_data_q.delete();
    beat(OP_DATA, 32'h0000_0006);
    chk("t1_no_wr_lo", {63'd0, inst_wr_en}, 64'd0);
    beat(OP_DATA, 32'h0000_0001);
    chk("t1_wr_en", {63'd0, inst_wr_en}, 64'd1);
    chk("t1_wr_addr", {55'd0, inst_wr_addr}, 64'd0);
    chk("t1_wr_data", inst_wr_data, 64'h0000_0001_0000_0006);
    chk("t1_len", {54'd0, loaded_len}, 64'd1);
    chk("t1_start_pre", {63'd0, control_start}, 64'd0);
    beat(OP_COMMIT, 32'h0);
    chk("t1_wr_en_off", {63'd0, inst_wr_en}, 64'd0);
    chk("t1_start", {63'd0, control_start}, 64'd1);
    chk("t1_busy", {63'd0, busy}, 64'd0);
    chk("t1_errs", {61'd0, err_overflow, err_odd, err_seq}, 64'd0);
    chk("t1_nwr", wr_addr_q.size(), 64'd1);

    // Test 2: BEGIN while running, filters busy for 5 cycles
    filt_idle = 1'b0;
    beat(OP_BEGIN, 32'h0);
    chk("t2_start_fall", {63'd0, control_start}, 64'd0);
    chk("t2_wready_0", {63'd0, cfg_if.cfg_wready}, 64'd0);
    for (int i = 1; i < 5; i++) begin
      idle_cycles(1);
      chk("t2_wready_hold", {63'd0, cfg_if.cfg_wready}, 64'd0);
    end
    filt_idle = 1'b1;
    idle_cycles(1);
    chk("t2_loading_wready", {63'd0, cfg_if.cfg_wready}, 64'd1);
    chk("t2_loading_busy", {63'd0, busy}, 64'd1);
    chk("t2_len", {54'd0, loaded_len}, 64'd0);

    // Test 3: 1026 back-to-back DATA beats overflow a 512-slot memory
    wr_addr_q.delete();
    wr_data_q.delete();
    for (int i = 0; i < 1026; i++) begin
      if (i == 1024) chk("t3_ovf_before", {63'd0, err_overflow}, 64'd0);
      beat(OP_DATA, i);
    end
    @(negedge clk);
    chk("t3_nwr", wr_addr_q.size(), 64'd512);
    bad = 0;
    for (int k = 0; k < wr_addr_q.size(); k++)
      if (wr_addr_q[k] !== 9'(k)) bad++;
    chk("t3_addr_seq", bad, 64'd0);
    chk("t3_data_first", wr_data_q[0], 64'h0000_0001_0000_0000);
    chk("t3_data_last", wr_data_q[511], {32'd1023, 32'd1022});
    chk("t3_ovf", {63'd0, err_overflow}, 64'd1);
    chk("t3_len", {54'd0, loaded_len}, 64'd512);
    @(posedge clk);
    #1;

    // Test 4: odd beat count before COMMIT
    beat(OP_BEGIN, 32'h0);
    chk("t4_ovf_clr", {63'd0, err_overflow}, 64'd0);
    wait_ready();
    wr_addr_q.delete();
    wr_data_q.delete();
    beat(OP_DATA, 32'hAAAA_0000);
    beat(OP_DATA, 32'hBBBB_1111);
    beat(OP_DATA, 32'hCCCC_2222);
    beat(OP_COMMIT, 32'h0);
    chk("t4_odd", {63'd0, err_odd}, 64'd1);
    chk("t4_start", {63'd0, control_start}, 64'd1);
    chk("t4_len", {54'd0, loaded_len}, 64'd1);
    @(negedge clk);
    chk("t4_nwr", wr_addr_q.size(), 64'd1);
    chk("t4_data", wr_data_q[0], 64'hBBBB_1111_AAAA_0000);
    @(posedge clk);
    #1;

    // Test 5: DATA while stopped is dropped and flagged
    beat(OP_ABORT, 32'h0);
    chk("t5_abort_start", {63'd0, control_start}, 64'd0);
    wr_addr_q.delete();
    beat(OP_DATA, 32'h1234_5678);
    beat(OP_DATA, 32'h9ABC_DEF0);
    idle_cycles(1);
    chk("t5_seq", {63'd0, err_seq}, 64'd1);
    chk("t5_nwr", wr_addr_q.size(), 64'd0);
    beat(OP_BEGIN, 32'h0);
    chk("t5_seq_clr", {63'd0, err_seq}, 64'd0);
    wait_ready();

    // Test 6: asynchronous reset after lo half of instruction 3
    for (int i = 0; i < 7; i++) beat(OP_DATA, 32'h100 + i);
    chk("t6_len_pre", {54'd0, loaded_len}, 64'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_len", {54'd0, loaded_len}, 64'd0);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_wr", {inst_wr_data[63:1], inst_wr_en}, 64'd0);
    chk("t6_rst_addr", {55'd0, inst_wr_addr}, 64'd0);
    chk("t6_rst_start", {63'd0, control_start}, 64'd0);
    chk("t6_rst_wready", {63'd0, cfg_if.cfg_wready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(3);
    chk("t6_post_start", {63'd0, control_start}, 64'd0);
    chk("t6_post_busy", {63'd0, busy}, 64'd0);
    beat(OP_DATA, 32'h0);
    chk("t6_post_seq", {63'd0, err_seq}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
